// File: rtl/rf_wport_arbiter.sv
// Purpose: arbitrates the register-file write port between WB and queued MDU results, with busy scoreboard.
// Latency: port outputs are combinational; an MDU result can reach the port the cycle after it is pushed.
// Backpressure: mdu_ready drops when the FIFO is full; wb_hold stalls WB while a starved FIFO head is forced out.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_we,
    input  logic [4:0]              wb_addr,
    input  logic [31:0]             wb_data,
    output logic                    wb_hold,
    input  logic                    mdu_issue,
    input  logic [4:0]              mdu_issue_addr,
    output logic                    mdu_issue_rdy,
    input  logic                    mdu_valid,
    input  logic [4:0]              mdu_addr,
    input  logic [31:0]             mdu_data,
    output logic                    mdu_ready,
    input  logic [4:0]              dec_ra,
    input  logic [4:0]              dec_rb,
    input  logic [4:0]              dec_rd,
    output logic                    hazard,
    output logic                    rf_L_S,
    output logic [4:0]              rf_Wt_addr,
    output logic [31:0]             rf_Wt_data,
    output logic [31:0]             busy_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      addr_mem_q [DEPTH];
    logic [4:0]      addr_mem_d [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     data_mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;

    logic            wb_req;
    logic            wb_win;
    logic            fifo_empty;
    logic            fifo_drive;
    logic            push;
    logic            pop;
    logic [4:0]      head_addr;
    logic [31:0]     head_data;

    assign wb_req     = wb_we && (wb_addr != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];
    // In FORCE the head owns the port regardless of WB; otherwise WB has priority.
    assign fifo_drive = !fifo_empty && ((state_q == ST_FORCE) || !wb_req);
    assign wb_win     = wb_req && (state_q == ST_NORMAL);
    assign mdu_ready  = (count_q < DEPTH_C);
    assign push       = mdu_valid && mdu_ready;
    assign pop        = fifo_drive;

    assign wb_hold       = (state_q == ST_FORCE);
    assign fifo_count    = count_q;
    assign busy_mask     = busy_q;
    assign mdu_issue_rdy = !busy_q[mdu_issue_addr];
    // busy[0] is held at 0, so a zero register index can never raise a hazard.
    assign hazard        = busy_q[dec_ra] | busy_q[dec_rb] | busy_q[dec_rd];

    // Write-port mux: FIFO head, WB, or idle (all zero).
    always_comb begin
        rf_L_S     = 1'b0;
        rf_Wt_addr = 5'd0;
        rf_Wt_data = 32'd0;
        if (fifo_drive) begin
            rf_L_S     = 1'b1;
            rf_Wt_addr = head_addr;
            rf_Wt_data = head_data;
        end else if (wb_win) begin
            rf_L_S     = 1'b1;
            rf_Wt_addr = wb_addr;
            rf_Wt_data = wb_data;
        end
    end

    // Next-state for FIFO storage, pointers, occupancy, starvation counter, FSM and scoreboard.
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        busy_d     = busy_q;

        if (push) begin
            addr_mem_d[wr_ptr_q] = mdu_addr;
            data_mem_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Count consecutive losses of a waiting head to WB; any pop resets it.
        if (pop) begin
            starve_d = '0;
        end else if (wb_win && !fifo_empty && (starve_q != STARVE_C)) begin
            starve_d = starve_q + 1'b1;
        end

        state_d = ST_NORMAL;
        if ((state_q == ST_NORMAL) && (starve_d == STARVE_C)) begin
            state_d = ST_FORCE;
        end

        // Issue never targets a busy register, so clearing before setting cannot lose an update.
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (mdu_issue && mdu_issue_rdy && (mdu_issue_addr != 5'd0)) begin
            busy_d[mdu_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards any queued results and reservations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_NORMAL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule
